sb_mix_columns_seq: RTL and testbench



---
 rtl/sb_mix_columns_seq.sv | 118 +++++++++++
 tb/tb_sb_mix_columns_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sb_mix_columns_seq.sv
// S-AES MixColumns / InvMixColumns stage over GF(2^4) mod x^4+x+1, one column
// per cycle (SERIAL=1) or both columns at once, with a final-round bypass.
module sb_mix_columns_seq #(
    parameter bit          SERIAL    = 1'b1,
    parameter logic [15:0] RST_STATE = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_state,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_inv,
    input  logic        in_bypass,
    output logic [15:0] out_state,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] COL0 = 2'd1;
    localparam logic [1:0] COL1 = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] work_q, work_d;
    logic [15:0] out_q, out_d;
    logic        inv_q, inv_d;
    logic        vld_q, vld_d;
    logic [7:0]  col0_res, col1_res;

    function automatic logic [3:0] xt(input logic [3:0] x);
        return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    endfunction

    // Column is {a, b}: forward uses [1 4; 4 1], inverse [9 2; 2 9].
    function automatic logic [7:0] mix_col(input logic [7:0] c, input logic inv);
        logic [3:0] a, b, a2, b2, a4, b4, a9, b9;
        a  = c[7:4];
        b  = c[3:0];
        a2 = xt(a);
        b2 = xt(b);
        a4 = xt(a2);
        b4 = xt(b2);
        a9 = xt(a4) ^ a;
        b9 = xt(b4) ^ b;
        if (inv) return {a9 ^ b2, a2 ^ b9};
        return {a ^ b4, a4 ^ b};
    endfunction

    assign col0_res = mix_col(work_q[15:8], inv_q);
    assign col1_res = mix_col(work_q[7:0], inv_q);

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        out_d   = out_q;
        inv_d   = inv_q;
        vld_d   = vld_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d = in_state;
                    inv_d  = in_inv;
                    if (in_bypass) begin
                        out_d   = in_state;
                        vld_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = COL0;
                    end
                end
            end
            COL0: begin
                if (SERIAL) begin
                    work_d[15:8] = col0_res;
                    state_d      = COL1;
                end else begin
                    out_d   = {col0_res, col1_res};
                    vld_d   = 1'b1;
                    state_d = DONE;
                end
            end
            COL1: begin
                out_d   = {work_q[15:8], col1_res};
                vld_d   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= 16'h0000;
            out_q   <= RST_STATE;
            inv_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            out_q   <= out_d;
            inv_q   <= inv_d;
            vld_q   <= vld_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_state = out_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_sb_mix_columns_seq.sv
// Bench for sb_mix_columns_seq: a serial and a parallel build share the same
// stimulus; results are checked against a generic GF(2^4) matrix model.
module tb_sb_mix_columns_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_state;
    logic        in_valid, in_inv, in_bypass, out_ready;
    logic        in_ready1, out_valid1, in_ready0, out_valid0;
    logic [15:0] out_state1, out_state0;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    sb_mix_columns_seq #(.SERIAL(1'b1), .RST_STATE(16'h0000)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_state(in_state), .in_valid(in_valid),
        .in_ready(in_ready1), .in_inv(in_inv), .in_bypass(in_bypass),
        .out_state(out_state1), .out_valid(out_valid1), .out_ready(out_ready));

    sb_mix_columns_seq #(.SERIAL(1'b0), .RST_STATE(16'h0000)) dut_p (
        .clk(clk), .rst_n(rst_n), .in_state(in_state), .in_valid(in_valid),
        .in_ready(in_ready0), .in_inv(in_inv), .in_bypass(in_bypass),
        .out_state(out_state0), .out_valid(out_valid0), .out_ready(out_ready));

    // Generic carry-less multiply reduced by x^4+x+1.
    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 4; i++)
            if (b[i]) p = p ^ (8'(a) << i);
        for (int i = 7; i >= 4; i--)
            if (p[i]) p = p ^ (8'h13 << (i - 4));
        return p[3:0];
    endfunction

    function automatic logic [15:0] ref_mix(input logic [15:0] s, input logic inv, input logic byp);
        logic [3:0]  m00, m01, m10, m11, a, b;
        logic [15:0] r;
        if (byp) return s;
        if (inv) begin m00 = 4'h9; m01 = 4'h2; m10 = 4'h2; m11 = 4'h9; end
        else     begin m00 = 4'h1; m01 = 4'h4; m10 = 4'h4; m11 = 4'h1; end
        r = s;
        for (int c = 0; c < 2; c++) begin
            a = s[15 - 8*c -: 4];
            b = s[11 - 8*c -: 4];
            r[15 - 8*c -: 4] = gmul(m00, a) ^ gmul(m01, b);
            r[11 - 8*c -: 4] = gmul(m10, a) ^ gmul(m11, b);
        end
        return r;
    endfunction

    // One transaction on both builds; early=1 raises out_ready from accept on.
    task automatic run_op(input logic [15:0] s, input logic inv, input logic byp,
                          input logic early, input int hold,
                          output logic [15:0] r1, output logic [15:0] r0);
        int          lat1, lat0, exp_l1, exp_l0;
        logic [15:0] exp;
        exp    = ref_mix(s, inv, byp);
        exp_l1 = byp ? 1 : 3;
        exp_l0 = byp ? 1 : 2;
        in_state = s; in_inv = inv; in_bypass = byp; in_valid = 1'b1; out_ready = early;
        @(posedge clk); #1;
        in_valid = 1'b0; in_inv = ~inv; in_bypass = ~byp; in_state = 16'($urandom);
        lat1 = 0; lat0 = 0; r1 = 16'h0; r0 = 16'h0;
        for (int c = 1; c <= 5; c++) begin
            if (out_valid1 && lat1 == 0) begin lat1 = c; r1 = out_state1; end
            if (out_valid0 && lat0 == 0) begin lat0 = c; r0 = out_state0; end
            if (c < 5) begin @(posedge clk); #1; end
        end
        nvec++;
        if (lat1 !== exp_l1) begin nerr++; $display("FAIL lat_serial s=%h got %0d want %0d", s, lat1, exp_l1); end
        nvec++;
        if (lat0 !== exp_l0) begin nerr++; $display("FAIL lat_par s=%h got %0d want %0d", s, lat0, exp_l0); end
        nvec++;
        if (r1 !== exp) begin nerr++; $display("FAIL res_serial s=%h inv=%b byp=%b got %h want %h", s, inv, byp, r1, exp); end
        nvec++;
        if (r0 !== exp) begin nerr++; $display("FAIL res_par s=%h inv=%b byp=%b got %h want %h", s, inv, byp, r0, exp); end
        if (early) begin
            nvec++;
            if ({out_valid1, out_valid0, in_ready1, in_ready0} !== 4'b0011) begin
                nerr++; $display("FAIL early_release got %b want 0011", {out_valid1, out_valid0, in_ready1, in_ready0});
            end
        end else begin
            in_valid = 1'b1; in_state = ~s;
            for (int h = 0; h <= hold; h++) begin
                nvec++;
                if ({out_valid1, out_valid0, in_ready1, in_ready0, out_state1, out_state0} !== {4'b1100, exp, exp}) begin
                    nerr++;
                    $display("FAIL hold cyc=%0d got v=%b%b r=%b%b %h %h want v=11 r=00 %h",
                             h, out_valid1, out_valid0, in_ready1, in_ready0, out_state1, out_state0, exp);
                end
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            nvec++;
            if ({out_valid1, out_valid0, in_ready1, in_ready0} !== 4'b0011) begin
                nerr++; $display("FAIL release got %b want 0011", {out_valid1, out_valid0, in_ready1, in_ready0});
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_state = 16'h0; in_valid = 1'b0; in_inv = 1'b0;
        in_bypass = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if ({out_valid1, out_valid0, in_ready1, in_ready0, out_state1, out_state0} !== {4'b0011, 32'h0}) begin
            nerr++; $display("FAIL reset got v=%b%b r=%b%b %h %h want v=00 r=11 0000 0000",
                             out_valid1, out_valid0, in_ready1, in_ready0, out_state1, out_state0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_known();
        logic [15:0] r1, r0;
        logic [15:0] vin  [4] = '{16'h1200, 16'hFFFF, 16'h9600, 16'h6666};
        logic        vinv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] vout [4] = '{16'h9600, 16'h6666, 16'h1200, 16'hFFFF};
        for (int i = 0; i < 4; i++) begin
            run_op(vin[i], vinv[i], 1'b0, 1'b0, 1, r1, r0);
            nvec++;
            if (r1 !== vout[i] || r0 !== vout[i]) begin
                nerr++; $display("FAIL known%0d got %h %h want %h", i, r1, r0, vout[i]);
            end
        end
    endtask

    task automatic test_bypass();
        logic [15:0] r1, r0;
        run_op(16'hA5C3, 1'b0, 1'b1, 1'b0, 2, r1, r0);
        run_op(16'hA5C3, 1'b1, 1'b1, 1'b1, 0, r1, r0);
    endtask

    task automatic test_backpressure();
        logic [15:0] r1, r0;
        run_op(16'h1200, 1'b0, 1'b0, 1'b0, 10, r1, r0);
    endtask

    task automatic test_reset_midop();
        in_state = 16'($urandom); in_inv = 1'b0; in_bypass = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({out_valid1, out_valid0, in_ready1, in_ready0, out_state1, out_state0} !== {4'b0011, 32'h0}) begin
            nerr++; $display("FAIL midop_reset got v=%b%b r=%b%b %h %h want v=00 r=11 0000 0000",
                             out_valid1, out_valid0, in_ready1, in_ready0, out_state1, out_state0);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            nvec++;
            if ({out_valid1, out_valid0, in_ready1, in_ready0} !== 4'b0011) begin
                nerr++; $display("FAIL stale_out cyc=%0d got %b want 0011", c, {out_valid1, out_valid0, in_ready1, in_ready0});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] x, r1, r0, q1, q0;
        logic        inv, byp, early;
        for (int i = 0; i < 100; i++) begin
            x     = 16'($urandom);
            inv   = 1'($urandom);
            byp   = ($urandom_range(0, 7) == 0);
            early = 1'($urandom);
            run_op(x, inv, byp, early, $urandom_range(0, 3), r1, r0);
            if (!byp && !inv) begin
                run_op(r1, 1'b1, 1'b0, early, 0, q1, q0);
                nvec++;
                if (q1 !== x || q0 !== x) begin
                    nerr++; $display("FAIL roundtrip x=%h got %h %h", x, q1, q0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_bypass();
        test_backpressure();
        test_reset_midop();
        test_known();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
